// File: rtl/cke_uart_tx_pkg.sv
// Shared types and helpers for the clock-enable driven UART transmitter.
package cke_uart_tx_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    sIdle   = 3'd0,
    sArm    = 3'd1,
    sStart  = 3'd2,
    sData   = 3'd3,
    sParity = 3'd4,
    sStop   = 3'd5
  } txState_t;

  // Parity mode selectors accepted by the pParity parameter
  localparam string cParityNone = "none";
  localparam string cParityEven = "even";
  localparam string cParityOdd  = "odd";

  // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit)
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : cke_uart_tx_pkg

// File: rtl/cke_uart_tx.sv
// UART transmitter paced by an external one-cycle baud tick (iCke).
// Frame: start bit, pDataWidth data bits LSB first, optional parity, pStopBits stop bits.
module cke_uart_tx
  import cke_uart_tx_pkg::*;
#(
  parameter int unsigned pDataWidth = 8,
  parameter string       pParity    = "none",
  parameter int unsigned pStopBits  = 1
) (
  input  logic                  iSysClk,
  input  logic                  iSysRst,
  input  logic                  iCke,
  input  logic [pDataWidth-1:0] iData,
  input  logic                  iValid,
  output logic                  oReady,
  output logic                  oTxd,
  output logic                  oBusy,
  output logic                  oDone
);

  localparam bit          cParEn    = (pParity != cParityNone);
  localparam bit          cParInv   = (pParity == cParityOdd);
  localparam int unsigned cCntW     = cntWidth(pDataWidth);
  localparam int unsigned cStopW    = cntWidth(pStopBits);

  localparam logic [cCntW-1:0]  cLastBit  = cCntW'(pDataWidth - 1);
  localparam logic [cStopW-1:0] cLastStop = cStopW'(pStopBits - 1);

  txState_t              state;
  logic [pDataWidth-1:0] shiftReg;
  logic                  parityBit;
  logic [cCntW-1:0]      bitCnt;
  logic [cStopW-1:0]     stopCnt;

  // Frame sequencer: state, shifter, counters and all outputs advance together,
  // and every line transition happens on an edge where iCke is sampled high.
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      state     <= sIdle;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      bitCnt    <= '0;
      stopCnt   <= '0;
      oTxd      <= 1'b1;
      oReady    <= 1'b1;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
    end else begin
      oDone <= 1'b0;
      unique case (state)
        sIdle: begin
          // Baud ticks are ignored here; only a handshake starts a frame
          if (iValid && oReady) begin
            shiftReg  <= iData;
            parityBit <= (^iData) ^ cParInv;
            oReady    <= 1'b0;
            oBusy     <= 1'b1;
            state     <= sArm;
          end
        end
        sArm: begin
          // Wait for a tick so the start bit spans a full baud interval
          if (iCke) begin
            oTxd   <= 1'b0;
            bitCnt <= '0;
            state  <= sStart;
          end
        end
        sStart: begin
          if (iCke) begin
            oTxd     <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
            state    <= sData;
          end
        end
        sData: begin
          if (iCke) begin
            bitCnt <= bitCnt + cCntW'(1);
            if (bitCnt == cLastBit) begin
              if (cParEn) begin
                oTxd  <= parityBit;
                state <= sParity;
              end else begin
                oTxd    <= 1'b1;
                stopCnt <= '0;
                state   <= sStop;
              end
            end else begin
              oTxd     <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
            end
          end
        end
        sParity: begin
          if (iCke) begin
            oTxd    <= 1'b1;
            stopCnt <= '0;
            state   <= sStop;
          end
        end
        sStop: begin
          if (iCke) begin
            if (stopCnt == cLastStop) begin
              oDone  <= 1'b1;
              oReady <= 1'b1;
              oBusy  <= 1'b0;
              state  <= sIdle;
            end else begin
              stopCnt <= stopCnt + cStopW'(1);
            end
          end
        end
        default: begin
          oTxd   <= 1'b1;
          oReady <= 1'b1;
          oBusy  <= 1'b0;
          state  <= sIdle;
        end
      endcase
    end
  end

endmodule : cke_uart_tx

// File: tb/tb_cke_uart_tx.sv
// Directed bench for cke_uart_tx: four instances cover 8N1, 8E1, 8O1 and 8N2.
module tb_cke_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       cke;
  logic       valid;
  logic [7:0] data;
  logic [3:0] ready, txd, busy, done;

  int nVec = 0;
  int nErr = 0;
  int ckePeriod = 0;
  int ckeCnt = 0;

  always #5 clk = ~clk;

  cke_uart_tx #(.pDataWidth(8), .pParity("none"), .pStopBits(1)) u8n1 (
    .iSysClk(clk), .iSysRst(rst), .iCke(cke), .iData(data), .iValid(valid),
    .oReady(ready[0]), .oTxd(txd[0]), .oBusy(busy[0]), .oDone(done[0]));
  cke_uart_tx #(.pDataWidth(8), .pParity("even"), .pStopBits(1)) u8e1 (
    .iSysClk(clk), .iSysRst(rst), .iCke(cke), .iData(data), .iValid(valid),
    .oReady(ready[1]), .oTxd(txd[1]), .oBusy(busy[1]), .oDone(done[1]));
  cke_uart_tx #(.pDataWidth(8), .pParity("odd"), .pStopBits(1)) u8o1 (
    .iSysClk(clk), .iSysRst(rst), .iCke(cke), .iData(data), .iValid(valid),
    .oReady(ready[2]), .oTxd(txd[2]), .oBusy(busy[2]), .oDone(done[2]));
  cke_uart_tx #(.pDataWidth(8), .pParity("none"), .pStopBits(2)) u8n2 (
    .iSysClk(clk), .iSysRst(rst), .iCke(cke), .iData(data), .iValid(valid),
    .oReady(ready[3]), .oTxd(txd[3]), .oBusy(busy[3]), .oDone(done[3]));

  // Advance one clock, sample point 1ns after the edge, and schedule the next baud tick
  task automatic tick();
    @(posedge clk);
    #1;
    if (ckePeriod > 0) begin
      ckeCnt = (ckeCnt + 1) % ckePeriod;
      cke = (ckeCnt == 0);
    end else begin
      cke = 1'b0;
    end
  endtask

  task automatic applyReset();
    rst = 1'b1; valid = 1'b0; data = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Step until the selected line drops to the start bit; ok=0 if it never does
  task automatic waitStart(input logic [1:0] sel, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 64) begin
      if (txd[sel] === 1'b0) ok = 1'b1;
      else begin tick(); n++; end
    end
  endtask

  // Record n per-clock samples of the selected instance, offset 0 = current sample
  task automatic capture(input logic [1:0] sel, input int n,
                         output logic [127:0] sTxd, output logic [127:0] sRdy,
                         output logic [127:0] sDone);
    sTxd = '0; sRdy = '0; sDone = '0;
    for (int i = 0; i < n; i++) begin
      sTxd[7'(i)]  = txd[sel];
      sRdy[7'(i)]  = ready[sel];
      sDone[7'(i)] = done[sel];
      if (i < n - 1) tick();
    end
  endtask

  task automatic test_reset();
    bit sawLow, sawBusy;
    rst = 1'b1; valid = 1'b0; data = 8'h00; ckePeriod = 3;
    tick(); tick();
    nVec++; if (txd !== 4'hF) begin nErr++; $display("FAIL reset_txd: got %b expected 1111", txd); end
    nVec++; if (busy !== 4'h0) begin nErr++; $display("FAIL reset_busy: got %b expected 0000", busy); end
    nVec++; if (done !== 4'h0) begin nErr++; $display("FAIL reset_done: got %b expected 0000", done); end
    rst = 1'b0;
    tick();
    nVec++; if (ready !== 4'hF) begin nErr++; $display("FAIL reset_ready: got %b expected 1111", ready); end
    sawLow = 1'b0; sawBusy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (txd !== 4'hF) sawLow = 1'b1;
      if (busy !== 4'h0 || done !== 4'h0) sawBusy = 1'b1;
    end
    nVec++; if (sawLow) begin nErr++; $display("FAIL idle_cke_txd: got line activity expected idle high"); end
    nVec++; if (sawBusy) begin nErr++; $display("FAIL idle_cke_busy: got busy/done expected none"); end
  endtask

  task automatic test_8n1();
    logic [127:0] sTxd, sRdy, sDone;
    logic [9:0]   fr;
    logic [3:0]   got, exp;
    bit ok;
    applyReset();
    ckePeriod = 4;
    data = 8'hA5; valid = 1'b1;
    tick();
    valid = 1'b0;
    nVec++; if (ready[0] !== 1'b0) begin nErr++; $display("FAIL 8n1_accept_ready: got %b expected 0", ready[0]); end
    nVec++; if (busy[0] !== 1'b1) begin nErr++; $display("FAIL 8n1_accept_busy: got %b expected 1", busy[0]); end
    nVec++; if (txd[0] !== 1'b1) begin nErr++; $display("FAIL 8n1_arm_txd: got %b expected 1", txd[0]); end
    waitStart(2'd0, ok);
    nVec++; if (!ok) begin nErr++; $display("FAIL 8n1_start_timeout: got no start bit expected one"); end
    capture(2'd0, 44, sTxd, sRdy, sDone);
    fr = 10'b1_1010_0101_0;
    for (int b = 0; b < 10; b++) begin
      got = sTxd[7'(4*b) +: 4];
      exp = {4{fr[b]}};
      nVec++; if (got !== exp) begin nErr++; $display("FAIL 8n1_bit%0d: got %b expected %b", b, got, exp); end
    end
    nVec++; if (sDone !== (128'(1) << 40)) begin nErr++; $display("FAIL 8n1_done: got %h expected %h", sDone, 128'(1) << 40); end
    nVec++; if (sRdy !== (128'hF << 40)) begin nErr++; $display("FAIL 8n1_ready: got %h expected %h", sRdy, 128'hF << 40); end
  endtask

  task automatic test_parity();
    logic [1:0] sels [3] = '{2'd1, 2'd2, 2'd1};
    logic [7:0] bytes [3] = '{8'hA5, 8'hA5, 8'h01};
    logic       expPar [3] = '{1'b0, 1'b1, 1'b1};
    logic [127:0] sTxd, sRdy, sDone;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      applyReset();
      ckePeriod = 1;
      data = bytes[k]; valid = 1'b1;
      tick();
      valid = 1'b0;
      waitStart(sels[k], ok);
      nVec++; if (!ok) begin nErr++; $display("FAIL par%0d_start_timeout: got no start bit expected one", k); end
      capture(sels[k], 12, sTxd, sRdy, sDone);
      nVec++; if (sTxd[8:1] !== bytes[k]) begin nErr++; $display("FAIL par%0d_data: got %h expected %h", k, sTxd[8:1], bytes[k]); end
      nVec++; if (sTxd[9] !== expPar[k]) begin nErr++; $display("FAIL par%0d_bit: got %b expected %b", k, sTxd[9], expPar[k]); end
      nVec++; if (sDone[11:0] !== 12'h800) begin nErr++; $display("FAIL par%0d_done: got %h expected 800", k, sDone[11:0]); end
    end
  endtask

  task automatic test_stop2();
    logic [127:0] sTxd, sRdy, sDone;
    bit ok;
    applyReset();
    ckePeriod = 1;
    data = 8'h00; valid = 1'b1;
    tick();
    valid = 1'b0;
    waitStart(2'd3, ok);
    nVec++; if (!ok) begin nErr++; $display("FAIL stop2_start_timeout: got no start bit expected one"); end
    capture(2'd3, 13, sTxd, sRdy, sDone);
    nVec++; if (sTxd[10:0] !== 11'b110_0000_0000) begin nErr++; $display("FAIL stop2_line: got %b expected 11000000000", sTxd[10:0]); end
    nVec++; if (sDone[12:0] !== 13'h0800) begin nErr++; $display("FAIL stop2_done: got %h expected 0800", sDone[12:0]); end
    nVec++; if (sTxd[12:11] !== 2'b11) begin nErr++; $display("FAIL stop2_idle: got %b expected 11", sTxd[12:11]); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] sTxd, sRdy, sDone, expTxd, expMark;
    logic [9:0] fr1, fr2;
    bit ok;
    applyReset();
    ckePeriod = 2;
    data = 8'h55; valid = 1'b1;
    tick();
    nVec++; if (ready[0] !== 1'b0) begin nErr++; $display("FAIL b2b_accept_ready: got %b expected 0", ready[0]); end
    data = 8'h0F;
    waitStart(2'd0, ok);
    nVec++; if (!ok) begin nErr++; $display("FAIL b2b_start_timeout: got no start bit expected one"); end
    capture(2'd0, 43, sTxd, sRdy, sDone);
    valid = 1'b0;
    fr1 = {1'b1, 8'h55, 1'b0};
    fr2 = {1'b1, 8'h0F, 1'b0};
    expTxd = '0;
    for (int i = 0; i < 43; i++) begin
      if (i < 20)      expTxd[7'(i)] = fr1[i / 2];
      else if (i < 22) expTxd[7'(i)] = 1'b1;
      else if (i < 42) expTxd[7'(i)] = fr2[(i - 22) / 2];
      else             expTxd[7'(i)] = 1'b1;
    end
    expMark = (128'(1) << 20) | (128'(1) << 42);
    nVec++; if (sTxd !== expTxd) begin nErr++; $display("FAIL b2b_line: got %h expected %h", sTxd, expTxd); end
    nVec++; if (sRdy !== expMark) begin nErr++; $display("FAIL b2b_ready: got %h expected %h", sRdy, expMark); end
    nVec++; if (sDone !== expMark) begin nErr++; $display("FAIL b2b_done: got %h expected %h", sDone, expMark); end
  endtask

  task automatic test_reset_midframe();
    bit ok, sawDone, sawLow;
    applyReset();
    ckePeriod = 2;
    data = 8'hFF; valid = 1'b1;
    tick();
    valid = 1'b0;
    waitStart(2'd0, ok);
    nVec++; if (!ok) begin nErr++; $display("FAIL rstmid_start_timeout: got no start bit expected one"); end
    for (int i = 0; i < 8; i++) tick();
    nVec++; if (busy[0] !== 1'b1) begin nErr++; $display("FAIL rstmid_inframe_busy: got %b expected 1", busy[0]); end
    rst = 1'b1;
    tick();
    nVec++; if (txd[0] !== 1'b1) begin nErr++; $display("FAIL rstmid_txd: got %b expected 1", txd[0]); end
    nVec++; if (busy[0] !== 1'b0) begin nErr++; $display("FAIL rstmid_busy: got %b expected 0", busy[0]); end
    nVec++; if (done[0] !== 1'b0) begin nErr++; $display("FAIL rstmid_done: got %b expected 0", done[0]); end
    rst = 1'b0;
    tick();
    nVec++; if (ready[0] !== 1'b1) begin nErr++; $display("FAIL rstmid_ready: got %b expected 1", ready[0]); end
    sawDone = 1'b0; sawLow = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done[0] !== 1'b0) sawDone = 1'b1;
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) sawLow = 1'b1;
      tick();
    end
    nVec++; if (sawDone) begin nErr++; $display("FAIL rstmid_no_done: got a done pulse expected none"); end
    nVec++; if (sawLow) begin nErr++; $display("FAIL rstmid_idle: got activity expected idle line"); end
  endtask

  task automatic test_arm_ignore();
    logic [127:0] sTxd, sRdy, sDone;
    logic [7:0]   got;
    bit ok;
    applyReset();
    ckePeriod = 8; ckeCnt = 0; cke = 1'b0;
    data = 8'h3C; valid = 1'b1;
    tick();
    data = 8'hC3; valid = 1'b1;
    tick();
    valid = 1'b0; data = 8'h00;
    nVec++; if (txd[0] !== 1'b1) begin nErr++; $display("FAIL arm_txd: got %b expected 1", txd[0]); end
    nVec++; if (busy[0] !== 1'b1) begin nErr++; $display("FAIL arm_busy: got %b expected 1", busy[0]); end
    waitStart(2'd0, ok);
    nVec++; if (!ok) begin nErr++; $display("FAIL arm_start_timeout: got no start bit expected one"); end
    capture(2'd0, 81, sTxd, sRdy, sDone);
    for (int b = 0; b < 8; b++) got[b] = sTxd[7'(8*(b+1) + 4)];
    nVec++; if (got !== 8'h3C) begin nErr++; $display("FAIL arm_payload: got %h expected 3c", got); end
    nVec++; if (sDone !== (128'(1) << 80)) begin nErr++; $display("FAIL arm_done: got %h expected %h", sDone, 128'(1) << 80); end
  endtask

  initial begin
    rst = 1'b1; cke = 1'b0; valid = 1'b0; data = 8'h00;
    test_reset();
    test_8n1();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_reset_midframe();
    test_arm_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule : tb_cke_uart_tx
